npi_frame_reader: RTL and testbench

Read-side counterpart of the image write path. Fetches a frame buffer from DRAM over the MPMC NPI port in 32-word (128-byte) read bursts and streams it out as 32-bit words on an FSL master link. The downstream display/compositing logic consumes it there. Runs continuously, wrapping to the frame base after the last burst, and marks the first word of each frame with FSL_M_Control.

---
 rtl/npi_frame_reader_pkg.sv | 18 +
 rtl/npi_frame_reader_if.sv | 52 +++++
 rtl/npi_rd_skid_fifo.sv | 49 ++++
 rtl/npi_frame_reader.sv | 158 +++++++++++++++
 tb/tb_npi_frame_reader.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npi_frame_reader_pkg.sv
// Shared types and constants for the NPI frame reader: FSM states and
// burst/skid geometry.
package npi_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_REQ,
    ST_DRAIN
  } state_e;

  localparam logic [3:0] NPI_SIZE_32W = 4'd4;
  localparam int BURST_DWORDS = 16;
  localparam int BURST_BYTES  = 128;
  localparam int SKID_DEPTH   = 4;
  localparam int SKID_PTR_W   = 2;
  localparam int SKID_CNT_W   = 3;

endpackage

// File: rtl/npi_frame_reader_if.sv
// NPI read port plus FSL master link. The reader drives the master modport;
// the MPMC and the downstream sink sit on the slave modport.
interface npi_frame_reader_if #(
  parameter int C_PI_ADDR_WIDTH     = 32,
  parameter int C_PI_DATA_WIDTH     = 64,
  parameter int C_PI_BE_WIDTH       = 8,
  parameter int C_PI_RDWDADDR_WIDTH = 4
);
  logic [C_PI_ADDR_WIDTH-1:0]     XIL_NPI_Addr;
  logic                           XIL_NPI_AddrReq;
  logic                           XIL_NPI_AddrAck;
  logic                           XIL_NPI_RNW;
  logic [3:0]                     XIL_NPI_Size;
  logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_WrFIFO_Data;
  logic [C_PI_BE_WIDTH-1:0]       XIL_NPI_WrFIFO_BE;
  logic                           XIL_NPI_WrFIFO_Push;
  logic                           XIL_NPI_WrFIFO_Flush;
  logic                           XIL_NPI_RdModWr;
  logic                           XIL_NPI_WrFIFO_Empty;
  logic                           XIL_NPI_WrFIFO_AlmostFull;
  logic [C_PI_RDWDADDR_WIDTH-1:0] XIL_NPI_RdFIFO_RdWdAddr;
  logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_RdFIFO_Data;
  logic                           XIL_NPI_RdFIFO_Pop;
  logic                           XIL_NPI_RdFIFO_Empty;
  logic                           XIL_NPI_RdFIFO_Flush;
  logic [1:0]                     XIL_NPI_RdFIFO_Latency;
  logic                           XIL_NPI_InitDone;
  logic                           FSL_M_Write;
  logic [0:31]                    FSL_M_Data;
  logic                           FSL_M_Control;
  logic                           FSL_M_Full;

  modport master (
    output XIL_NPI_Addr, XIL_NPI_AddrReq, XIL_NPI_RNW, XIL_NPI_Size,
           XIL_NPI_WrFIFO_Data, XIL_NPI_WrFIFO_BE, XIL_NPI_WrFIFO_Push,
           XIL_NPI_WrFIFO_Flush, XIL_NPI_RdModWr, XIL_NPI_RdFIFO_Pop,
           XIL_NPI_RdFIFO_Flush, FSL_M_Write, FSL_M_Data, FSL_M_Control,
    input  XIL_NPI_AddrAck, XIL_NPI_WrFIFO_Empty, XIL_NPI_WrFIFO_AlmostFull,
           XIL_NPI_RdFIFO_RdWdAddr, XIL_NPI_RdFIFO_Data, XIL_NPI_RdFIFO_Empty,
           XIL_NPI_RdFIFO_Latency, XIL_NPI_InitDone, FSL_M_Full
  );

  modport slave (
    input  XIL_NPI_Addr, XIL_NPI_AddrReq, XIL_NPI_RNW, XIL_NPI_Size,
           XIL_NPI_WrFIFO_Data, XIL_NPI_WrFIFO_BE, XIL_NPI_WrFIFO_Push,
           XIL_NPI_WrFIFO_Flush, XIL_NPI_RdModWr, XIL_NPI_RdFIFO_Pop,
           XIL_NPI_RdFIFO_Flush, FSL_M_Write, FSL_M_Data, FSL_M_Control,
    output XIL_NPI_AddrAck, XIL_NPI_WrFIFO_Empty, XIL_NPI_WrFIFO_AlmostFull,
           XIL_NPI_RdFIFO_RdWdAddr, XIL_NPI_RdFIFO_Data, XIL_NPI_RdFIFO_Empty,
           XIL_NPI_RdFIFO_Latency, XIL_NPI_InitDone, FSL_M_Full
  );
endinterface

// File: rtl/npi_rd_skid_fifo.sv
// Four-entry 64-bit skid FIFO between the NPI read port and the FSL
// serializer. The head entry is visible without a pop (show-ahead).
module npi_rd_skid_fifo
  import npi_frame_reader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [63:0]           i_pushData,
  input  logic                  i_pop,
  output logic [63:0]           o_headData,
  output logic [SKID_CNT_W-1:0] o_count,
  output logic                  o_empty,
  output logic                  o_full
);
  logic [63:0]           r_mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] r_wrPtr;
  logic [SKID_PTR_W-1:0] r_rdPtr;
  logic [SKID_CNT_W-1:0] r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == SKID_CNT_W'(SKID_DEPTH));
  assign o_count    = r_count;
  assign o_headData = r_mem[r_rdPtr];
  assign w_doPop    = i_pop && !o_empty;
  assign w_doPush   = i_push && (!o_full || w_doPop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end
endmodule

// File: rtl/npi_frame_reader.sv
// Streams a DRAM frame buffer out of the MPMC NPI port in 32-word bursts and
// serializes it onto an FSL master link, flagging the first word of each frame.
module npi_frame_reader
  import npi_frame_reader_pkg::*;
#(
  parameter int          C_PI_ADDR_WIDTH = 32,
  parameter int          C_PI_DATA_WIDTH = 64,
  parameter int          C_PI_BE_WIDTH   = 8,
  parameter logic [31:0] C_BASE_ADDR     = 32'h0000_0000,
  parameter int          C_FRAME_BURSTS  = 9600
) (
  input logic               FSL_Clk,
  input logic               FSL_Rst,
  input logic               FSL_M_Clk,
  input logic               system_dcm_locked,
  npi_frame_reader_if.master npi
);
  localparam int FRAME_WORDS = 2 * BURST_DWORDS * C_FRAME_BURSTS;
  localparam int WCNT_W      = $clog2(FRAME_WORDS);
  localparam int BURST_W     = (C_FRAME_BURSTS > 1) ? $clog2(C_FRAME_BURSTS) : 1;

  state_e                     r_state;
  logic                       r_addrReq;
  logic [C_PI_ADDR_WIDTH-1:0] r_addr;
  logic                       r_flush;
  logic [4:0]                 r_popped;
  logic [BURST_W-1:0]         r_burst;
  logic [1:0]                 r_popDly;
  logic                       r_half;
  logic [WCNT_W-1:0]          r_wordCnt;

  logic                  w_pop;
  logic                  w_skidPush;
  logic [SKID_CNT_W-1:0] w_inflight;
  logic [SKID_CNT_W-1:0] w_skidCount;
  logic                  w_skidEmpty;
  logic                  w_skidFull;
  logic [63:0]           w_head;
  logic                  w_write;
  logic                  w_xfer;
  logic                  w_unused;

  assign npi.XIL_NPI_RNW          = 1'b1;
  assign npi.XIL_NPI_Size         = NPI_SIZE_32W;
  assign npi.XIL_NPI_WrFIFO_Data  = {C_PI_DATA_WIDTH{1'b0}};
  assign npi.XIL_NPI_WrFIFO_BE    = {C_PI_BE_WIDTH{1'b0}};
  assign npi.XIL_NPI_WrFIFO_Push  = 1'b0;
  assign npi.XIL_NPI_WrFIFO_Flush = 1'b0;
  assign npi.XIL_NPI_RdModWr      = 1'b0;
  assign npi.XIL_NPI_AddrReq      = r_addrReq;
  assign npi.XIL_NPI_Addr         = r_addr;
  assign npi.XIL_NPI_RdFIFO_Flush = r_flush;
  assign npi.XIL_NPI_RdFIFO_Pop   = w_pop;

  assign w_unused = ^{FSL_M_Clk, npi.XIL_NPI_WrFIFO_Empty,
                      npi.XIL_NPI_WrFIFO_AlmostFull, npi.XIL_NPI_RdFIFO_RdWdAddr, w_skidFull};

  // Pops still travelling through the latency pipe hold a reserved skid slot.
  always_comb begin
    w_inflight = '0;
    w_skidPush = 1'b0;
    case (npi.XIL_NPI_RdFIFO_Latency)
      2'd0: begin
        w_skidPush = w_pop;
      end
      2'd1: begin
        w_inflight = {{(SKID_CNT_W-1){1'b0}}, r_popDly[0]};
        w_skidPush = r_popDly[0];
      end
      default: begin
        w_inflight = {{(SKID_CNT_W-1){1'b0}}, r_popDly[0]} + {{(SKID_CNT_W-1){1'b0}}, r_popDly[1]};
        w_skidPush = r_popDly[1];
      end
    endcase
  end

  assign w_pop = (r_state == ST_DRAIN) && !npi.XIL_NPI_RdFIFO_Empty &&
                 (r_popped < 5'(BURST_DWORDS)) &&
                 (({1'b0, w_skidCount} + {1'b0, w_inflight}) < (SKID_CNT_W+1)'(SKID_DEPTH));

  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      r_state   <= ST_INIT;
      r_addrReq <= 1'b0;
      r_addr    <= C_PI_ADDR_WIDTH'(C_BASE_ADDR);
      r_flush   <= 1'b1;
      r_popped  <= '0;
      r_burst   <= '0;
      r_popDly  <= '0;
    end else begin
      r_popDly <= {r_popDly[0], w_pop};
      case (r_state)
        ST_INIT: begin
          r_flush   <= 1'b1;
          r_addrReq <= 1'b0;
          if (npi.XIL_NPI_InitDone && system_dcm_locked) begin
            r_state   <= ST_REQ;
            r_addrReq <= 1'b1;
            r_flush   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (npi.XIL_NPI_AddrAck) begin
            r_addrReq <= 1'b0;
            r_popped  <= '0;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_popped <= r_popped + 1'b1;
            if (r_popped == 5'(BURST_DWORDS - 1)) begin
              r_state   <= ST_REQ;
              r_addrReq <= 1'b1;
              if (r_burst == BURST_W'(C_FRAME_BURSTS - 1)) begin
                r_burst <= '0;
                r_addr  <= C_PI_ADDR_WIDTH'(C_BASE_ADDR);
              end else begin
                r_burst <= r_burst + 1'b1;
                r_addr  <= r_addr + C_PI_ADDR_WIDTH'(BURST_BYTES);
              end
            end
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  npi_rd_skid_fifo u_skid (
    .i_clk      (FSL_Clk),
    .i_rst_n    (FSL_Rst),
    .i_push     (w_skidPush),
    .i_pushData (npi.XIL_NPI_RdFIFO_Data),
    .i_pop      (w_xfer && r_half),
    .o_headData (w_head),
    .o_count    (w_skidCount),
    .o_empty    (w_skidEmpty),
    .o_full     (w_skidFull)
  );

  assign w_write           = !w_skidEmpty;
  assign w_xfer            = w_write && !npi.FSL_M_Full;
  assign npi.FSL_M_Write   = w_write;
  assign npi.FSL_M_Data    = w_write ? (r_half ? w_head[31:0] : w_head[63:32]) : 32'h0;
  assign npi.FSL_M_Control = w_write && (r_wordCnt == '0);

  // Upper half of each doubleword goes first; the frame word counter marks word 0.
  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      r_half    <= 1'b0;
      r_wordCnt <= '0;
    end else if (w_xfer) begin
      r_half    <= ~r_half;
      r_wordCnt <= (r_wordCnt == WCNT_W'(FRAME_WORDS - 1)) ? '0 : r_wordCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_npi_frame_reader.sv
// Randomized bench for npi_frame_reader: an NPI memory/FSL sink model with a
// frame-level scoreboard drives and checks the reader.
module tb_npi_frame_reader;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          FRAMES = 3;
  localparam int          WPF    = 32 * FRAMES;

  logic clk = 1'b0;
  logic rst_n;
  logic dcm;
  always #5 clk = ~clk;

  npi_frame_reader_if npi ();

  npi_frame_reader #(
    .C_BASE_ADDR   (BASE),
    .C_FRAME_BURSTS(FRAMES)
  ) dut (
    .FSL_Clk          (clk),
    .FSL_Rst          (rst_n),
    .FSL_M_Clk        (clk),
    .system_dcm_locked(dcm),
    .npi              (npi.master)
  );

  int nPass = 0;
  int nTotal = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTotal++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // DRAM contents: word n of the frame (counting from 1) holds the value n.
  function automatic logic [63:0] dwordAt(input logic [31:0] addr, input int k);
    logic [31:0] hi;
    hi = ((addr - BASE) >> 2) + 32'(2 * k) + 32'd1;
    return {hi, hi + 32'd1};
  endfunction

  logic [63:0] rq[$];
  logic [63:0] pend[$];
  logic [31:0] expQ[$];
  logic [31:0] reqAddrs[$];
  int          ctrlWords[$];
  logic [63:0] d1, d2;
  int          wordsSinceReset, pops, maxOut, popsInBurst, burstIdx;
  int          fullMode;
  logic [31:0] firstWord;
  bit          gotFirst;
  bit          prevStall;
  logic [31:0] prevData;

  // NPI memory + FSL sink model with scoreboard.
  initial begin
    logic s_write, s_full, s_ctrl, s_pop, s_req, s_ack, s_flush;
    logic [31:0] s_data, s_addr, e, expAddr;
    logic [63:0] v;
    int out;
    npi.XIL_NPI_AddrAck      = 1'b0;
    npi.XIL_NPI_RdFIFO_Empty = 1'b1;
    npi.XIL_NPI_RdFIFO_Data  = '0;
    npi.FSL_M_Full           = 1'b0;
    d1 = '0;
    d2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete(); pend.delete(); expQ.delete(); reqAddrs.delete(); ctrlWords.delete();
        wordsSinceReset = 0; pops = 0; maxOut = 0; popsInBurst = 0; burstIdx = 0;
        gotFirst = 0; prevStall = 0;
        npi.XIL_NPI_AddrAck      = 1'b0;
        npi.XIL_NPI_RdFIFO_Empty = 1'b1;
        continue;
      end
      s_write = npi.FSL_M_Write;  s_full = npi.FSL_M_Full;  s_ctrl = npi.FSL_M_Control;
      s_data  = npi.FSL_M_Data;   s_pop  = npi.XIL_NPI_RdFIFO_Pop;
      s_req   = npi.XIL_NPI_AddrReq; s_ack = npi.XIL_NPI_AddrAck;
      s_addr  = npi.XIL_NPI_Addr; s_flush = npi.XIL_NPI_RdFIFO_Flush;

      if (prevStall) begin
        checkOutput("hold_write", 64'(s_write), 64'd1);
        checkOutput("hold_data", 64'(s_data), 64'(prevData));
      end
      prevStall = s_write && s_full;
      prevData  = s_data;

      if (s_write && !s_full) begin
        if (expQ.size() == 0) checkOutput("fsl_extra", 64'd1, 64'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("fsl_data", 64'(s_data), 64'(e));
        end
        checkOutput("fsl_ctrl", 64'(s_ctrl), ((wordsSinceReset % WPF) == 0) ? 64'd1 : 64'd0);
        if (s_ctrl) ctrlWords.push_back(wordsSinceReset);
        if (!gotFirst) begin
          firstWord = s_data;
          gotFirst  = 1;
        end
        wordsSinceReset++;
      end

      if (s_pop) begin
        pops++;
        popsInBurst++;
        if (rq.size() == 0) checkOutput("pop_empty", 64'd1, 64'd0);
      end
      out = pops - wordsSinceReset / 2;
      if (out > maxOut) maxOut = out;

      if (s_req && s_ack) begin
        expAddr = BASE + 32'(128 * burstIdx);
        checkOutput("req_addr", 64'(s_addr), 64'(expAddr));
        reqAddrs.push_back(s_addr);
        burstIdx = (burstIdx + 1) % FRAMES;
        for (int k = 0; k < 16; k++) begin
          pend.push_back(dwordAt(s_addr, k));
          v = dwordAt(expAddr, k);
          expQ.push_back(v[63:32]);
          expQ.push_back(v[31:0]);
        end
        popsInBurst = 0;
      end

      @(posedge clk);
      #1;
      if (!rst_n) continue;
      v = {$urandom, $urandom};
      if (s_pop && rq.size() > 0) v = rq.pop_front();
      d2 = d1;
      if (s_pop) d1 = v;
      if (s_flush) begin
        rq.delete();
        pend.delete();
      end
      if (pend.size() > 0 && rq.size() < 32 && $urandom_range(0, 1) == 1) rq.push_back(pend.pop_front());
      if (s_req && s_ack) npi.XIL_NPI_AddrAck = 1'b0;
      else if (npi.XIL_NPI_AddrReq && !npi.XIL_NPI_AddrAck && $urandom_range(0, 2) == 0)
        npi.XIL_NPI_AddrAck = 1'b1;
      npi.XIL_NPI_RdFIFO_Empty = (rq.size() == 0);
      case (npi.XIL_NPI_RdFIFO_Latency)
        2'd0:    npi.XIL_NPI_RdFIFO_Data = (rq.size() > 0) ? rq[0] : {$urandom, $urandom};
        2'd1:    npi.XIL_NPI_RdFIFO_Data = d1;
        default: npi.XIL_NPI_RdFIFO_Data = d2;
      endcase
      case (fullMode)
        0:       npi.FSL_M_Full = 1'b0;
        1:       npi.FSL_M_Full = ($urandom_range(0, 1) == 1);
        default: npi.FSL_M_Full = 1'b1;
      endcase
    end
  end

  task automatic waitWords(input string tag, input int n);
    int c = 0;
    while (wordsSinceReset < n && c < 20000) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 64'(wordsSinceReset >= n), 64'd1);
  endtask

  // Asynchronous reset, then bring the memory up with the given read latency.
  task automatic applyStimulus(input logic [1:0] lat, input int mode);
    @(posedge clk);
    #2 rst_n = 1'b0;
    npi.XIL_NPI_InitDone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    npi.XIL_NPI_RdFIFO_Latency = lat;
    fullMode = mode;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 npi.XIL_NPI_InitDone = 1'b1;
    dcm = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_addrreq"}, 64'(npi.XIL_NPI_AddrReq), 64'd0);
    checkOutput({tag, "_addr"}, 64'(npi.XIL_NPI_Addr), 64'(BASE));
    checkOutput({tag, "_pop"}, 64'(npi.XIL_NPI_RdFIFO_Pop), 64'd0);
    checkOutput({tag, "_flush"}, 64'(npi.XIL_NPI_RdFIFO_Flush), 64'd1);
    checkOutput({tag, "_write"}, 64'(npi.FSL_M_Write), 64'd0);
    checkOutput({tag, "_data"}, 64'(npi.FSL_M_Data), 64'd0);
    checkOutput({tag, "_ctrl"}, 64'(npi.FSL_M_Control), 64'd0);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int c, p150, w0;
    rst_n = 1'b0;
    dcm   = 1'b0;
    fullMode = 0;
    npi.XIL_NPI_InitDone          = 1'b0;
    npi.XIL_NPI_RdFIFO_Latency    = 2'd1;
    npi.XIL_NPI_WrFIFO_Empty      = 1'b1;
    npi.XIL_NPI_WrFIFO_AlmostFull = 1'b0;
    npi.XIL_NPI_RdFIFO_RdWdAddr   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("rst");
    checkOutput("rnw", 64'(npi.XIL_NPI_RNW), 64'd1);
    checkOutput("size", 64'(npi.XIL_NPI_Size), 64'd4);
    checkOutput("wr_push", 64'({npi.XIL_NPI_WrFIFO_Push, npi.XIL_NPI_WrFIFO_Flush, npi.XIL_NPI_RdModWr}), 64'd0);

    // Init gating: InitDone without dcm_locked must keep the reader idle.
    @(posedge clk);
    #1 rst_n = 1'b1;
    npi.XIL_NPI_InitDone = 1'b1;
    ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (npi.XIL_NPI_AddrReq !== 1'b0 || npi.XIL_NPI_RdFIFO_Flush !== 1'b1) ok = 0;
    end
    checkOutput("gate_hold", 64'(ok), 64'd1);
    @(posedge clk);
    #1 dcm = 1'b1;
    @(negedge clk);
    checkOutput("req_before", 64'(npi.XIL_NPI_AddrReq), 64'd0);
    @(negedge clk);
    checkOutput("req_rise", 64'(npi.XIL_NPI_AddrReq), 64'd1);
    checkOutput("req_addr0", 64'(npi.XIL_NPI_Addr), 64'(BASE));
    checkOutput("flush_off", 64'(npi.XIL_NPI_RdFIFO_Flush), 64'd0);

    // First burst and frame wrap at latency 1, no backpressure.
    waitWords("wait_burst", 32);
    checkOutput("first_word", 64'(firstWord), 64'd1);
    waitWords("wait_wrap", 2 * WPF + 1);
    checkOutput("req_count", 64'(reqAddrs.size() >= 4), 64'd1);
    if (reqAddrs.size() >= 4) begin
      checkOutput("req1_addr", 64'(reqAddrs[1]), 64'(BASE + 32'h80));
      checkOutput("req3_wrap", 64'(reqAddrs[3]), 64'(BASE));
    end
    checkOutput("ctrl_count", 64'(ctrlWords.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      checkOutput("ctrl_idx", 64'((i < ctrlWords.size()) ? ctrlWords[i] : -1), 64'(i * WPF));

    // Backpressure held long: pops stop once four doublewords are buffered.
    @(posedge clk);
    #1 fullMode = 2;
    repeat (150) @(negedge clk);
    p150 = pops;
    repeat (50) @(negedge clk);
    checkOutput("pop_stall", 64'(pops), 64'(p150));
    checkOutput("skid_fill", 64'(pops - wordsSinceReset / 2), 64'd4);
    @(posedge clk);
    #1 fullMode = 1;
    w0 = wordsSinceReset;
    waitWords("wait_resume", w0 + 100);

    // Latency sweep with random backpressure.
    for (int lat = 0; lat < 3; lat++) begin
      applyStimulus(2'(lat), 1);
      waitWords("wait_lat", 300);
      checkOutput("max_skid", 64'(maxOut <= 4), 64'd1);
    end

    // Reset in the middle of a non-base burst after seven pops.
    c = 0;
    while (!(popsInBurst == 7 && reqAddrs.size() > 0 && reqAddrs[reqAddrs.size()-1] != BASE) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    checkOutput("wait_7pops", 64'(c < 20000), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    npi.XIL_NPI_InitDone = 1'b0;
    #1;
    checkResetOutputs("async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (npi.XIL_NPI_RdFIFO_Flush !== 1'b1 || npi.XIL_NPI_AddrReq !== 1'b0) ok = 0;
    end
    checkOutput("flush_until_init", 64'(ok), 64'd1);
    @(posedge clk);
    #1 npi.XIL_NPI_InitDone = 1'b1;
    waitWords("wait_restart", 1);
    checkOutput("restart_word", 64'(firstWord), 64'd1);
    checkOutput("restart_ctrl", 64'(ctrlWords.size() > 0 && ctrlWords[0] == 0), 64'd1);
    waitWords("wait_tail", 64);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
